// File: rtl/sme_driver.sv
// sme_driver: host-side transmitter for the string-match engine (SME).
//
// Collects one string (up to STR_MAX chars) and one pattern (up to PAT_MAX
// chars) from an upstream valid/ready byte stream. It then serialises them
// onto chardata/isstring/ispattern, waits for the engine's valid strobe, and
// holds the result for the host until res_ready.
//
// Ports
//   clk, reset                  rising-edge clock, async active-low reset
//   in_valid/in_ready/in_data   upstream byte stream
//   in_is_pat, in_last          stream type (first beat only) / end marker
//   chardata/isstring/ispattern registered character bus to the SME
//   valid/match/match_index     SME result strobe and payload
//   res_valid/res_ready         result handshake to the host
//   res_match/res_index/res_err captured result, error flag
module sme_driver #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_pat,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err
);

  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SIW = $clog2(STR_MAX);
  localparam int PIW = $clog2(PAT_MAX);
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_STR = 3'd1;
  localparam logic [2:0] S_LOAD_PAT = 3'd2;
  localparam logic [2:0] S_SEND_STR = 3'd3;
  localparam logic [2:0] S_SEND_PAT = 3'd4;
  localparam logic [2:0] S_WAIT_RES = 3'd5;
  localparam logic [2:0] S_REPORT   = 3'd6;

  logic [2:0]     r_state;
  logic [SLW-1:0] r_str_len;
  logic [PLW-1:0] r_pat_len;
  logic           r_str_vld, r_str_new, r_ovf;
  logic [SIW-1:0] r_idx;
  logic [CW-1:0]  r_cnt;
  logic [7:0]     r_str [STR_MAX];
  logic [7:0]     r_pat [PAT_MAX];

  logic [7:0]     r_chardata;
  logic           r_isstring, r_ispattern;
  logic           r_res_valid, r_res_match, r_res_err;
  logic [4:0]     r_res_index;

  logic           w_load, w_beat, w_first, w_pat;
  logic [SLW-1:0] w_str_base;
  logic [PLW-1:0] w_pat_base;
  logic           w_str_full, w_pat_full, w_str_last, w_pat_last;

  assign w_load  = (r_state == S_IDLE) || (r_state == S_LOAD_STR) ||
                   (r_state == S_LOAD_PAT);
  // Gated by reset so every output reads 0 while reset is held.
  assign in_ready = reset & w_load;
  assign w_beat   = in_valid & in_ready;
  assign w_first  = (r_state == S_IDLE);
  // Stream type is latched by the state after the first beat.
  assign w_pat    = w_first ? in_is_pat : (r_state == S_LOAD_PAT);

  // The first beat of a new string/pattern restarts its length at 0.
  assign w_str_base = w_first ? '0 : r_str_len;
  assign w_pat_base = w_first ? '0 : r_pat_len;
  assign w_str_full = (w_str_base == SLW'(STR_MAX));
  assign w_pat_full = (w_pat_base == PLW'(PAT_MAX));

  assign w_str_last = (SLW'(r_idx) == r_str_len - SLW'(1));
  assign w_pat_last = (PLW'(r_idx) == r_pat_len - PLW'(1));

  // Character buffers carry no reset; lengths define what is valid.
  always_ff @(posedge clk) begin
    if (w_beat && !w_pat && !w_str_full) r_str[w_str_base[SIW-1:0]] <= in_data;
    if (w_beat &&  w_pat && !w_pat_full) r_pat[w_pat_base[PIW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_str_len   <= '0;
      r_pat_len   <= '0;
      r_str_vld   <= 1'b0;
      r_str_new   <= 1'b0;
      r_ovf       <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_chardata  <= '0;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= '0;
      r_res_err   <= 1'b0;
    end else begin
      // SME bus idles at zero unless a send state drives it this cycle.
      r_chardata  <= '0;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      if (w_beat) begin
        if (!w_pat) begin
          if (w_first) r_ovf <= 1'b0;
          if (w_str_full) r_ovf <= 1'b1;
          else            r_str_len <= w_str_base + SLW'(1);
          if (in_last) begin
            r_state   <= S_IDLE;
            r_str_vld <= 1'b1;
            r_str_new <= 1'b1;
          end else begin
            r_state   <= S_LOAD_STR;
          end
        end else begin
          if (w_pat_full) r_ovf <= 1'b1;
          else            r_pat_len <= w_pat_base + PLW'(1);
          r_idx <= '0;
          if (!in_last) begin
            r_state <= S_LOAD_PAT;
          end else if (!r_str_vld) begin
            // Nothing to match against: report an error without SME traffic.
            r_state     <= S_REPORT;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_res_match <= 1'b0;
            r_res_index <= '0;
          end else if (r_str_new) begin
            r_state <= S_SEND_STR;
          end else begin
            r_state <= S_SEND_PAT;
          end
        end
      end else begin
        case (r_state)
          S_SEND_STR: begin
            r_chardata <= r_str[r_idx];
            r_isstring <= 1'b1;
            r_str_new  <= 1'b0;
            if (w_str_last) begin
              r_idx   <= '0;
              r_state <= S_SEND_PAT;
            end else begin
              r_idx   <= r_idx + SIW'(1);
            end
          end
          S_SEND_PAT: begin
            r_chardata  <= r_pat[r_idx[PIW-1:0]];
            r_ispattern <= 1'b1;
            if (w_pat_last) begin
              r_cnt   <= '0;
              r_state <= S_WAIT_RES;
            end else begin
              r_idx   <= r_idx + SIW'(1);
            end
          end
          S_WAIT_RES: begin
            if (valid) begin
              r_state     <= S_REPORT;
              r_res_valid <= 1'b1;
              r_res_match <= match;
              r_res_index <= match_index;
              r_res_err   <= r_ovf;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
              r_state     <= S_REPORT;
              r_res_valid <= 1'b1;
              r_res_match <= 1'b0;
              r_res_index <= '0;
              r_res_err   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_REPORT: begin
            if (res_ready) begin
              r_res_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign chardata  = r_chardata;
  assign isstring  = r_isstring;
  assign ispattern = r_ispattern;
  assign res_valid = r_res_valid;
  assign res_match = r_res_match;
  assign res_index = r_res_index;
  assign res_err   = r_res_err;

endmodule
